// File: rtl/sobel_frame_ctrl.sv
// Frame/line sequencer for a camera-fed Sobel datapath: pixel coordinates, frame-stable enable,
// interior-pixel mask aligned to the datapath latency. Optional counters under SOBEL_FRAME_STATS_EN.
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIPE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       href_in,
  input  logic       mode_req,
  output logic       dp_vsync,
  output logic       dp_href,
  output logic       sobel_enable,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       out_mask,
  output logic       frame_done,
  output logic       line_err
`ifdef SOBEL_FRAME_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYNC    = 3'd1;
  localparam logic [2:0] ACTIVE  = 3'd2;
  localparam logic [2:0] HBLANK  = 3'd3;
  localparam logic [2:0] OVERRUN = 3'd4;

  localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_HEIGHT - 1);

  logic [2:0]          state_r, state_nx_s;
  logic [9:0]          row_r, row_nx_s;
  logic [9:0]          col_r, col_nx_s;
  logic                line_err_r, err_nx_s;
  logic                dp_vsync_r, dp_href_r, sobel_en_r, frame_done_r;
  logic [PIPE_DEPTH:0] mask_sr_r;
  logic                vsync_rise_s, accept_s, last_pix_s, mask_in_s;

  // Next-state, coordinate and error-flag decode; vsync rise overrides everything.
  always_comb begin
    vsync_rise_s = vsync_in & ~dp_vsync_r;
    state_nx_s   = state_r;
    row_nx_s     = row_r;
    col_nx_s     = col_r;
    err_nx_s     = line_err_r;
    accept_s     = 1'b0;
    if (vsync_rise_s) begin
      state_nx_s = SYNC;
      row_nx_s   = 10'd0;
      col_nx_s   = 10'd0;
      err_nx_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (href_in) begin
            state_nx_s = OVERRUN;
            err_nx_s   = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end
        SYNC: begin
          if (href_in && !vsync_in) begin
            state_nx_s = ACTIVE;
            accept_s   = 1'b1;
          end else begin
            state_nx_s = SYNC;
          end
        end
        ACTIVE: begin
          if (href_in) begin
            accept_s = 1'b1;
          end else if (col_r != 10'd0) begin
            // Short line: flag it and move on to the next row so the frame stays usable.
            err_nx_s = 1'b1;
            col_nx_s = 10'd0;
            if (row_r == ROW_LAST) begin
              state_nx_s = IDLE;
            end else begin
              state_nx_s = HBLANK;
              row_nx_s   = row_r + 10'd1;
            end
          end else begin
            state_nx_s = HBLANK;
          end
        end
        HBLANK: begin
          if (href_in) begin
            state_nx_s = ACTIVE;
            accept_s   = 1'b1;
          end else begin
            state_nx_s = HBLANK;
          end
        end
        OVERRUN: state_nx_s = OVERRUN;
        default: state_nx_s = IDLE;
      endcase
      if (accept_s) begin
        if (col_r == COL_LAST) begin
          col_nx_s = 10'd0;
          if (row_r == ROW_LAST) begin
            state_nx_s = IDLE;
          end else begin
            row_nx_s = row_r + 10'd1;
          end
        end else begin
          col_nx_s = col_r + 10'd1;
        end
      end else begin
        col_nx_s = col_nx_s;
      end
    end
    last_pix_s = accept_s && (row_r == ROW_LAST) && (col_r == COL_LAST);
    mask_in_s  = accept_s && (row_r >= 10'd2) && (col_r >= 10'd1);
  end

  // State, coordinates, datapath syncs and the mask delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      row_r        <= 10'd0;
      col_r        <= 10'd0;
      line_err_r   <= 1'b0;
      dp_vsync_r   <= 1'b0;
      dp_href_r    <= 1'b0;
      sobel_en_r   <= 1'b1;
      frame_done_r <= 1'b0;
      mask_sr_r    <= '0;
    end else begin
      state_r      <= state_nx_s;
      row_r        <= row_nx_s;
      col_r        <= col_nx_s;
      line_err_r   <= err_nx_s;
      dp_vsync_r   <= vsync_in;
      dp_href_r    <= href_in && (state_r != IDLE) && (state_r != OVERRUN);
      sobel_en_r   <= vsync_rise_s ? mode_req : sobel_en_r;
      frame_done_r <= last_pix_s;
      // Stage 0 lines up with dp_href; the tap PIPE_DEPTH stages later matches the datapath output.
      mask_sr_r    <= {mask_sr_r[PIPE_DEPTH-1:0], mask_in_s};
    end
  end

  assign dp_vsync     = dp_vsync_r;
  assign dp_href      = dp_href_r;
  assign sobel_enable = sobel_en_r;
  assign row          = row_r;
  assign col          = col_r;
  assign out_mask     = mask_sr_r[PIPE_DEPTH];
  assign frame_done   = frame_done_r;
  assign line_err     = line_err_r;

`ifdef SOBEL_FRAME_STATS_EN
  logic        line_err_q_r;
  logic [15:0] frame_cnt_r, err_cnt_r;

  // Frame counter wraps; error counter counts line_err rising edges and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_err_q_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
      err_cnt_r    <= 16'd0;
    end else begin
      line_err_q_r <= line_err_r;
      frame_cnt_r  <= frame_done_r ? (frame_cnt_r + 16'd1) : frame_cnt_r;
      if (line_err_r && !line_err_q_r && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign frame_count = frame_cnt_r;
  assign err_count   = err_cnt_r;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on an 8x4 image with a 4-cycle datapath.
module tb_sobel_frame_ctrl;
  localparam int W = 8;
  localparam int H = 4;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync_in = 1'b0;
  logic       href_in = 1'b0;
  logic       mode_req = 1'b1;
  logic       dp_vsync, dp_href, sobel_enable, out_mask, frame_done, line_err;
  logic [9:0] row, col;
`ifdef SOBEL_FRAME_STATS_EN
  logic [15:0] frame_count, err_count;
`endif

  int checks = 0;
  int failures = 0;

  sobel_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_DEPTH(P)) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .href_in(href_in), .mode_req(mode_req),
    .dp_vsync(dp_vsync), .dp_href(dp_href), .sobel_enable(sobel_enable),
    .row(row), .col(col), .out_mask(out_mask), .frame_done(frame_done), .line_err(line_err)
`ifdef SOBEL_FRAME_STATS_EN
    , .frame_count(frame_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Event monitor: pulse counts and timing of pixel (2,1) versus the first mask of each frame.
  int   cyc = 0, mask_n = 0, fd_n = 0, href_n = 0, hf = 0, t_h21 = 0, t_m1 = -1;
  logic vs_q = 1'b0;
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    vs_q   <= dp_vsync;
    mask_n <= out_mask ? mask_n + 1 : mask_n;
    fd_n   <= frame_done ? fd_n + 1 : fd_n;
    href_n <= dp_href ? href_n + 1 : href_n;
    if (dp_vsync && !vs_q) begin
      hf   <= 0;
      t_m1 <= -1;
    end else begin
      if (dp_href) begin
        hf <= hf + 1;
        if (hf == 2 * W + 1) t_h21 <= cyc;
      end
      if (out_mask && t_m1 < 0) t_m1 <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: vsync, then H lines of W pixels with 2-cycle gaps; optional short line 1 or reset.
  task automatic run_frame(input logic mreq, input logic exp_en, input int short_line,
                           input int rst_pix, input logic mid_toggle, input logic exp_err,
                           input logic chk_lat);
    int m0, f0, len;
    m0 = mask_n;
    f0 = fd_n;
    mode_req = mreq;
    vsync_in = 1'b1;
    tick();
    check_val("vs_sobel_en", 32'(sobel_enable), 32'(exp_en));
    check_val("vs_row_col", 32'({row, col}), 32'd0);
    check_val("vs_err_clr", 32'(line_err), 32'd0);
    tick();
    vsync_in = 1'b0;
    tick();
    tick();
    for (int l = 0; l < H; l++) begin
      len = (l == short_line) ? 5 : W;
      for (int p = 0; p < len; p++) begin
        href_in = 1'b1;
        if (mid_toggle && l == 1 && p == 0) mode_req = 1'b0;
        if (l * W + p == rst_pix) begin
          rst = 1'b1;
          tick();
          check_val("rst_row_col", 32'({row, col}), 32'd0);
          check_val("rst_outs", 32'({out_mask, frame_done, line_err, dp_href, dp_vsync}), 32'd0);
          check_val("rst_sobel_en", 32'(sobel_enable), 32'd1);
          rst = 1'b0;
          href_in = 1'b0;
          return;
        end
        tick();
      end
      href_in = 1'b0;
      tick();
      if (l == short_line) begin
        check_val("short_err", 32'(line_err), 32'd1);
        check_val("short_row", 32'(row), 32'd2);
        check_val("short_col", 32'(col), 32'd0);
      end
      tick();
    end
    for (int i = 0; i < 8; i++) tick();
    check_val("frame_done_n", 32'(fd_n - f0), 32'd1);
    check_val("mask_n", 32'(mask_n - m0), 32'd14);
    check_val("end_row", 32'(row), 32'd3);
    check_val("end_col", 32'(col), 32'd0);
    check_val("end_err", 32'(line_err), 32'(exp_err));
    if (chk_lat) check_val("mask_latency", 32'(t_m1 - t_h21), 32'd4);
  endtask

  initial begin
    int m0, h0;
    for (int i = 0; i < 3; i++) tick();
    check_val("reset_row_col", 32'({row, col}), 32'd0);
    check_val("reset_outs", 32'({out_mask, frame_done, line_err, dp_href, dp_vsync}), 32'd0);
    check_val("reset_sobel_en", 32'(sobel_enable), 32'd1);
    rst = 1'b0;
    tick();
    tick();

    // Clean frame; mode_req dropped mid-frame must not reach sobel_enable yet.
    run_frame(1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b1);
    check_val("sobel_en_hold", 32'(sobel_enable), 32'd1);
    // Short line 1, new mode applied at this vsync.
    run_frame(1'b0, 1'b0, 1, -1, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b1);

    // Extra line after frame_done with no vsync.
    m0 = mask_n;
    h0 = href_n;
    href_in = 1'b1;
    tick();
    check_val("ovr_err", 32'(line_err), 32'd1);
    for (int i = 0; i < W - 1; i++) tick();
    href_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_val("ovr_dp_href", 32'(href_n - h0), 32'd0);
    check_val("ovr_mask", 32'(mask_n - m0), 32'd0);
    check_val("ovr_err_sticky", 32'(line_err), 32'd1);

    // Reset at pixel (2,3): pending masks must be discarded.
    run_frame(1'b0, 1'b0, -1, 2 * W + 3, 1'b0, 1'b0, 1'b0);
    m0 = mask_n;
    for (int i = 0; i < 10; i++) tick();
    check_val("post_rst_mask", 32'(mask_n - m0), 32'd0);
    run_frame(1'b1, 1'b1, -1, -1, 1'b0, 1'b0, 1'b1);

`ifdef SOBEL_FRAME_STATS_EN
    run_frame(1'b1, 1'b1, -1, -1, 1'b0, 1'b0, 1'b1);
    run_frame(1'b1, 1'b1, -1, -1, 1'b0, 1'b0, 1'b1);
    run_frame(1'b1, 1'b1, 1, -1, 1'b0, 1'b1, 1'b0);
    check_val("frame_count", 32'(frame_count), 32'd4);
    check_val("err_count", 32'(err_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
